// File: rtl/sha256_pkg.sv
// Shared SHA-256 schedule definitions: word width, FSM encoding, round constants and sigma functions.
package sha256_pkg;

  localparam int SHA256_WORD = 32;

  typedef logic [SHA256_WORD-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam word_t K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Small sigma functions of the message schedule, rotations written as bit concatenations.
  function automatic word_t sched_s0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic word_t sched_s1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b00_0000_0000, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_sigma.sv
// Combinational schedule sigma of one word; SEL_S1 picks s1 (1) or s0 (0).
module sha256_sigma
  import sha256_pkg::*;
#(
  parameter bit SEL_S1 = 1'b0
) (
  input  logic [SHA256_WORD-1:0] x,
  output logic [SHA256_WORD-1:0] y
);

  // Select the sigma variant at elaboration time.
  always_comb begin
    y = '0;
    if (SEL_S1) begin
      y = sched_s1(x);
    end else begin
      y = sched_s0(x);
    end
  end

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: captures a 512-bit block and streams W[0..63] over a valid/ready handshake.
// Optional SHA256_SCHED_KT_EN adds a registered k_out = K[t_idx] aligned with w_out.
module sha256_msg_sched
  import sha256_pkg::*;
#(
  parameter int NROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [511:0] blk_in,
  input  logic        w_ready,
  output logic [31:0] w_out,
  output logic        w_valid,
  output logic [5:0]  t_idx,
  output logic        busy,
  output logic        done
`ifdef SHA256_SCHED_KT_EN
  ,
  output logic [31:0] k_out
`endif
);

  localparam logic [5:0] T_LAST = 6'(NROUNDS - 1);

  state_e       state_r;
  state_e       state_s;
  word_t        win_r [16];
  logic [5:0]   t_r;
  logic [5:0]   t_s;
  logic         valid_r;
  logic         done_r;
  logic         capture_s;
  logic         accept_s;
  word_t        s0_s;
  word_t        s1_s;
  word_t        w_new_s;

  sha256_sigma #(.SEL_S1(1'b0)) u_sigma0 (.x(win_r[1]),  .y(s0_s));
  sha256_sigma #(.SEL_S1(1'b1)) u_sigma1 (.x(win_r[14]), .y(s1_s));

  // valid_r always mirrors state_r==ST_RUN, so it doubles as the handshake qualifier.
  assign accept_s = valid_r & w_ready;
  assign w_new_s  = s1_s + win_r[9] + s0_s + win_r[0];

  // Next-state, next round index and capture strobe.
  always_comb begin
    state_s   = state_r;
    t_s       = t_r;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s   = ST_RUN;
          t_s       = 6'd0;
          capture_s = 1'b1;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          t_s = t_r + 6'd1;
          if (t_r == T_LAST) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          t_s = t_r;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, round index and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      t_r     <= 6'd0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      t_r     <= t_s;
      valid_r <= (state_s == ST_RUN);
      done_r  <= (state_s == ST_DONE);
    end
  end

  // Sliding 16-word window: load on capture, shift and append on each accepted word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        win_r[i] <= 32'd0;
      end
    end else if (capture_s) begin
      for (int i = 0; i < 16; i++) begin
        win_r[i] <= blk_in[511 - 32*i -: 32];
      end
    end else if (accept_s) begin
      for (int i = 0; i < 15; i++) begin
        win_r[i] <= win_r[i+1];
      end
      win_r[15] <= w_new_s;
    end
  end

  assign w_out   = win_r[0];
  assign t_idx   = t_r;
  assign w_valid = valid_r;
  assign busy    = valid_r;
  assign done    = done_r;

`ifdef SHA256_SCHED_KT_EN
  word_t k_r;

  // Round constant registered alongside the window so it lines up with w_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_r <= 32'd0;
    end else if (state_s == ST_RUN) begin
      k_r <= K_TABLE[t_s];
    end else begin
      k_r <= 32'd0;
    end
  end

  assign k_out = k_r;
`endif

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched: reference schedule computed from the FIPS recurrence,
// known "abc" vectors, stalls, ignored start, mid-block reset; k_out checks under SHA256_SCHED_KT_EN.
module tb_sha256_msg_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [511:0] blk_in;
  logic         w_ready;
  logic [31:0]  w_out;
  logic         w_valid;
  logic [5:0]   t_idx;
  logic         busy;
  logic         done;
`ifdef SHA256_SCHED_KT_EN
  logic [31:0]  k_out;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_w [64];
  logic [31:0] got_w [64];

  sha256_msg_sched #(.NROUNDS(64)) dut (
    .clk(clk), .rst(rst), .start(start), .blk_in(blk_in), .w_ready(w_ready),
    .w_out(w_out), .w_valid(w_valid), .t_idx(t_idx), .busy(busy), .done(done)
`ifdef SHA256_SCHED_KT_EN
    , .k_out(k_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference: full 64-word schedule from the textbook recurrence.
  task automatic model(input logic [511:0] b);
    for (int t = 0; t < 16; t++) exp_w[t] = b[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      exp_w[t] = (rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
               + exp_w[t-7]
               + (rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
               + exp_w[t-16];
    end
  endtask

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // Streams one block; optional random stalls, ignored start at start_at, reset at rst_at.
  task automatic run_block(input logic [511:0] blk, input bit rand_ready,
                           input int start_at, input int rst_at);
    int          acc = 0;
    bit          want_done = 1'b0;
    bit          finished = 1'b0;
    bit          hold = 1'b0;
    logic [31:0] prev_w = 32'd0;
    logic [5:0]  prev_t = 6'd0;
    model(blk);
    @(negedge clk);
    blk_in = blk; start = 1'b1; w_ready = 1'b0;
    @(negedge clk);
    for (int cyc = 0; cyc < 600; cyc++) begin
      start  = 1'b0;
      blk_in = blk;
      if (want_done) begin
        chk("done_after_w63", {31'd0, done}, 32'd1);
        chk("valid_in_done", {31'd0, w_valid}, 32'd0);
        chk("busy_in_done", {31'd0, busy}, 32'd0);
`ifdef SHA256_SCHED_KT_EN
        chk("k_out_done", k_out, 32'd0);
`endif
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("idle_valid", {31'd0, w_valid}, 32'd0);
        finished = 1'b1;
        break;
      end
      chk("no_early_done", {31'd0, done}, 32'd0);
      chk("valid_in_run", {31'd0, w_valid}, 32'd1);
      chk("busy_in_run", {31'd0, busy}, 32'd1);
      if (hold) begin
        chk("stall_w_stable", w_out, prev_w);
        chk("stall_t_stable", {26'd0, t_idx}, {26'd0, prev_t});
      end
      chk("t_idx", {26'd0, t_idx}, acc);
      chk("w_out", w_out, exp_w[acc]);
`ifdef SHA256_SCHED_KT_EN
      if (acc == 0)  chk("k_out_t0", k_out, 32'h428A2F98);
      if (acc == 63) chk("k_out_t63", k_out, 32'hC67178F2);
`endif
      if (acc == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_valid", {31'd0, w_valid}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_w_out", w_out, 32'd0);
        chk("rst_mid_t_idx", {26'd0, t_idx}, 32'd0);
        for (int i = 0; i < 70; i++) begin
          @(negedge clk);
          if (done) chk("no_done_after_rst", {31'd0, done}, 32'd0);
        end
        chk("idle_after_rst", {31'd0, busy}, 32'd0);
        finished = 1'b1;
        break;
      end
      if (acc == start_at) begin
        start  = 1'b1;
        blk_in = ~blk;
      end
      w_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      hold    = !w_ready;
      prev_w  = w_out;
      prev_t  = t_idx;
      if (w_ready) begin
        got_w[acc] = w_out;
        if (acc == 63) want_done = 1'b1;
        acc++;
      end
      @(negedge clk);
    end
    w_ready = 1'b0;
    start   = 1'b0;
    if (!finished) chk("block_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    string       name;
    int          idx;
    logic [31:0] exp;
  } vec_t;

  vec_t         tbl [5];
  logic [511:0] abc_blk;
  logic [511:0] nb;

  initial begin
    tbl[0] = '{"abc_w0",  0,  32'h61626380};
    tbl[1] = '{"abc_w15", 15, 32'h00000018};
    tbl[2] = '{"abc_w16", 16, 32'h61626380};
    tbl[3] = '{"abc_w17", 17, 32'h000F0000};
    tbl[4] = '{"abc_w63", 63, 32'h12B1EDEB};
    abc_blk = {32'h61626380, 448'd0, 32'h00000018};

    // Reset held 3 cycles with start asserted.
    rst = 1'b1; start = 1'b1; w_ready = 1'b1; blk_in = rand_blk();
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, w_valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_w_out", w_out, 32'd0);
    chk("rst_t_idx", {26'd0, t_idx}, 32'd0);
`ifdef SHA256_SCHED_KT_EN
    chk("rst_k_out", k_out, 32'd0);
`endif
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("start_in_rst_ignored", {31'd0, w_valid}, 32'd0);

    // "abc" at full rate, then checked against fixed vectors.
    run_block(abc_blk, 1'b0, -1, -1);
    for (int i = 0; i < 5; i++) chk(tbl[i].name, got_w[tbl[i].idx], tbl[i].exp);

    // Same block with random stalls, then with an ignored start at t=20.
    run_block(abc_blk, 1'b1, -1, -1);
    run_block(abc_blk, 1'b0, 20, -1);

    // Reset mid-block, then a fresh block must stream exactly.
    run_block(rand_blk(), 1'b0, -1, 30);
    nb = rand_blk();
    run_block(nb, 1'b1, -1, -1);
    for (int i = 0; i < 16; i++) chk("new_blk_word", got_w[i], nb[511 - 32*i -: 32]);

    for (int r = 0; r < 3; r++) run_block(rand_blk(), 1'b1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
